rf68000_ring_server: RTL and testbench
======================================

Name: rf68000_ring_server

Overview:
- Responder node for the rf68000 request/response packet rings. It sits at ring address ID (global server, default 62).
- Accepts PT_READ, PT_AREAD and PT_WRITE packets addressed to it and queues them in a request FIFO.
- Executes each request as a bus master cycle, then inserts PT_ACK, PT_AACK or PT_RETRY packets onto the response ring back to the requester.
- Also acts as ring root: ages all passing packets and drops orphaned ones.

Parameters:
- ID, 62, ring node address matched against packet did.
- FIFO_DEPTH, 4, request FIFO entries (power of 2, ≥2).
- AGE_MAX, 63, age at or above which a forwarded packet is dropped.
- TIMEOUT, 255, clocks to wait for m_ack_i before forcing bus termination.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- packet_i  in  packet_t  request ring in
- packet_o  out  packet_t  request ring out
- rpacket_i  in  packet_t  response ring in
- rpacket_o  out  packet_t  response ring out
- m_cyc_o  out  1  bus cycle
- m_stb_o  out  1  bus strobe
- m_ack_i  in  1  bus acknowledge
- m_we_o  out  1  bus write enable
- m_sel_o  out  4  byte selects
- m_adr_o  out  32  bus address
- m_dat_o  out  32  write data
- m_dat_i  in  32  read data
- busy_o  out  1  FIFO non-empty or bus engine not idle
- drop_o  out  1  one-clock pulse when a packet is aged out (either ring)
- tmo_o  out  1  one-clock pulse on bus timeout

Behaviour:

Reset:
- All outputs, FIFO pointers/count, rsp_tx, rty_tx, timeout counter and all packet registers are 0; state is IDLE.
- Reset mid-bus-cycle drops m_cyc_o/m_stb_o immediately and discards queued requests.

Empty slot:
- A slot is empty when (sid|did)==0.

Request ring (every clock):
- Default: packet_o <= packet_i with age+1 (saturating at 63).
- Non-empty packet_i with age ≥ AGE_MAX and did≠ID: packet_o <= 0 and drop_o pulses.
- packet_i.did==ID with typ in {PT_READ, PT_AREAD, PT_WRITE}:
  - FIFO not full: push the packet and set packet_o <= 0.
  - FIFO full, read type, rty_tx empty: set packet_o <= 0 and load rty_tx with {sid=ID, did=req.sid, age=0, typ=PT_RETRY, adr=req.adr, dat=0}.
  - FIFO full, otherwise (writes, or rty_tx occupied): forward normally so the packet recirculates.
- did==63 (broadcast) is never consumed; forward/age only.
- Other types addressed to ID: remove the packet and pulse drop_o.

Response ring (every clock):
- Default: rpacket_o <= rpacket_i, aged and dropped as on the request ring.
- If rpacket_i is an empty slot: insert rsp_tx if valid and clear it; otherwise insert rty_tx if valid and clear it.
- rsp_tx has priority over rty_tx.
- Only one insertion per cycle.

Bus engine states:
- IDLE: if FIFO non-empty and rsp_tx empty, pop the head and drive m_cyc_o=m_stb_o=1, m_we_o=(typ==PT_WRITE), m_adr_o=adr.
  - m_sel_o = sel for writes, 4'hF for reads.
  - m_dat_o = dat.
  - Clear the timer and go to BUS.
- BUS, on m_ack_i (sampled high):
  - Deassert cyc/stb/we, m_sel_o=0.
  - Read: load rsp_tx {sid=ID, did=req.sid, age=0, ack=1, typ=(PT_AREAD→PT_AACK, else PT_ACK), adr=m_adr_o, dat=m_dat_i}.
  - Write: no response.
  - Go to IDLE.
- BUS, timer reaching TIMEOUT without ack:
  - Same termination as on ack; tmo_o pulses.
  - Read data returned is 32'hFFFFFFFF.
- m_ack_i high in IDLE is ignored; a new cycle is not started while m_ack_i is still high.

Latency:
- Request present on packet_i at edge N with FIFO empty, engine IDLE and m_ack_i low: m_cyc_o is high after edge N+1.
- Ack sampled at edge M: rsp_tx valid after M; rpacket_o carries the response after edge M+1 if the slot at M+1 is empty.

Ordering and concurrency:
- Requests execute in FIFO order.
- Push and pop in the same cycle are both honoured; count is unchanged.
- busy_o = (count≠0) | (state≠IDLE).

Test Plan:
- PT_READ sid=3, adr=32'h4000_0010, empty rings, m_ack_i after 2 clks with dat 32'hCAFE_F00D → rpacket_o = PT_ACK, did=3, sid=62, adr 4000_0010, dat CAFE_F00D; packet_o slot cleared.
- PT_AREAD sid=5 → PT_AACK response; PT_WRITE sel=4'h3, dat 1234_5678 → m_we_o=1, m_sel_o=3, m_dat_o 1234_5678, no response packet.
- Hold m_ack_i low, send 5 reads (FIFO_DEPTH=4) → first 4 consumed, 5th generates PT_RETRY to its sid with matching adr; a 6th read while rty_tx is occupied is forwarded with age+1.
- rpacket_i continuously non-empty (foreign traffic) while rsp_tx is pending → no insertion and no new bus cycle started; insertion occurs in the first empty slot.
- No m_ack_i for 256 clks on a read → tmo_o pulse, ACK with dat FFFF_FFFF; packet with did=7, age=63 arriving → packet_o=0, drop_o pulse.
- Assert rst_i asynchronously mid-BUS → m_cyc_o falls without a clock; busy_o=0; all ring outputs 0.

Source files
------------

// File: rtl/rf68000_ring_server.sv
// ============================================================================
// rf68000_ring_server : ring responder/root node; queues requests, runs bus cycles, returns ACK/AACK/RETRY
// Revision: 1.0
// ============================================================================
`default_nettype none

package rf68000_ring_pkg;
  localparam logic [3:0] PT_NULL  = 4'd0;
  localparam logic [3:0] PT_READ  = 4'd1;
  localparam logic [3:0] PT_WRITE = 4'd2;
  localparam logic [3:0] PT_AREAD = 4'd3;
  localparam logic [3:0] PT_ACK   = 4'd4;
  localparam logic [3:0] PT_AACK  = 4'd5;
  localparam logic [3:0] PT_RETRY = 4'd6;

  typedef struct packed {
    logic [5:0]  did;
    logic [5:0]  sid;
    logic [5:0]  age;
    logic        ack;
    logic [3:0]  typ;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } packet_t;
endpackage

module rf68000_ring_server
  import rf68000_ring_pkg::*;
#(
  parameter int ID         = 62,
  parameter int FIFO_DEPTH = 4,
  parameter int AGE_MAX    = 63,
  parameter int TIMEOUT    = 255
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  packet_t     packet_i,
  output packet_t     packet_o,
  input  packet_t     rpacket_i,
  output packet_t     rpacket_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic        busy_o,
  output logic        drop_o,
  output logic        tmo_o
);

  localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = c_PW + 1;
  localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [5:0]      c_ID      = 6'(ID);
  localparam logic [5:0]      c_BCAST   = 6'd63;
  localparam logic [5:0]      c_AGE_MAX = 6'(AGE_MAX);
  localparam logic [c_CW-1:0] c_FULL    = c_CW'(FIFO_DEPTH);
  localparam logic [c_TW-1:0] c_TMO     = c_TW'(TIMEOUT);
  localparam logic [0:0]      c_IDLE    = 1'b0;
  localparam logic [0:0]      c_BUS     = 1'b1;

  function automatic logic f_empty(input packet_t p);
    return (p.sid | p.did) == 6'd0;
  endfunction

  function automatic packet_t f_aged(input packet_t p);
    packet_t q = p;
    if (p.age != 6'h3F) q.age = p.age + 6'd1;
    return q;
  endfunction

  packet_t         r_fifo [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0] r_count;
  packet_t         r_rsp_tx, r_rty_tx;
  logic [0:0]      r_state, w_state_nxt;
  logic [c_TW-1:0] r_timer;
  logic [3:0]      r_req_typ;
  logic [5:0]      r_req_sid;

  packet_t w_head, w_pkt_nxt, w_rpkt_nxt, w_rsp_new, w_rty_new;
  logic    w_full, w_is_req, w_rsp_valid, w_rty_valid, w_can_start, w_bus_end;
  logic    w_push, w_pop, w_finish, w_tmo;
  logic    w_rty_load, w_rty_clr, w_rsp_clr, w_req_drop, w_rsp_drop;
  logic    w_unused;

  assign w_head      = r_fifo[r_rd_ptr];
  assign w_full      = (r_count == c_FULL);
  assign w_rsp_valid = !f_empty(r_rsp_tx);
  assign w_rty_valid = !f_empty(r_rty_tx);
  assign w_is_req    = (packet_i.typ == PT_READ) || (packet_i.typ == PT_AREAD) ||
                       (packet_i.typ == PT_WRITE);
  assign w_can_start = (r_count != '0) && !w_rsp_valid && !m_ack_i;
  assign w_bus_end   = m_ack_i || (r_timer == c_TMO);
  assign busy_o      = (r_count != '0) || (r_state != c_IDLE);
  assign w_unused    = ^{w_head.did, w_head.age, w_head.ack};

  // Request ring: consume our requests, bounce reads with RETRY when full, age the rest
  always_comb begin
    w_pkt_nxt  = f_aged(packet_i);
    w_push     = 1'b0;
    w_rty_load = 1'b0;
    w_req_drop = 1'b0;
    w_rty_new      = '0;
    w_rty_new.sid  = c_ID;
    w_rty_new.did  = packet_i.sid;
    w_rty_new.typ  = PT_RETRY;
    w_rty_new.adr  = packet_i.adr;
    if (packet_i.did == c_ID && packet_i.did != c_BCAST && w_is_req) begin
      if (!w_full) begin
        w_push    = 1'b1;
        w_pkt_nxt = '0;
      end else if (packet_i.typ != PT_WRITE && !w_rty_valid) begin
        w_rty_load = 1'b1;
        w_pkt_nxt  = '0;
      end
    end else if (packet_i.did == c_ID && packet_i.did != c_BCAST) begin
      w_pkt_nxt  = '0;
      w_req_drop = 1'b1;
    end else if (!f_empty(packet_i) && packet_i.age >= c_AGE_MAX) begin
      w_pkt_nxt  = '0;
      w_req_drop = 1'b1;
    end
  end

  always_comb begin
    w_rpkt_nxt = f_aged(rpacket_i);
    w_rsp_clr  = 1'b0;
    w_rty_clr  = 1'b0;
    w_rsp_drop = 1'b0;
    if (f_empty(rpacket_i)) begin
      if (w_rsp_valid) begin
        w_rpkt_nxt = r_rsp_tx;
        w_rsp_clr  = 1'b1;
      end else if (w_rty_valid) begin
        w_rpkt_nxt = r_rty_tx;
        w_rty_clr  = 1'b1;
      end
    end else if (rpacket_i.did != c_ID && rpacket_i.age >= c_AGE_MAX) begin
      w_rpkt_nxt = '0;
      w_rsp_drop = 1'b1;
    end
  end

  always_comb begin
    w_rsp_new     = '0;
    w_rsp_new.sid = c_ID;
    w_rsp_new.did = r_req_sid;
    w_rsp_new.ack = 1'b1;
    w_rsp_new.typ = (r_req_typ == PT_AREAD) ? PT_AACK : PT_ACK;
    w_rsp_new.adr = m_adr_o;
    w_rsp_new.dat = m_ack_i ? m_dat_i : 32'hFFFF_FFFF;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_can_start) w_state_nxt = c_BUS;
      c_BUS:   if (w_bus_end)   w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_pop    = 1'b0;
    w_finish = 1'b0;
    w_tmo    = 1'b0;
    case (r_state)
      c_IDLE: w_pop = w_can_start;
      c_BUS: begin
        w_finish = w_bus_end;
        w_tmo    = !m_ack_i && (r_timer == c_TMO);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= packet_i;
        r_wr_ptr         <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PW'(1);
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      packet_o  <= '0;
      rpacket_o <= '0;
      r_rty_tx  <= '0;
      drop_o    <= 1'b0;
    end else begin
      packet_o  <= w_pkt_nxt;
      rpacket_o <= w_rpkt_nxt;
      drop_o    <= w_req_drop | w_rsp_drop;
      if (w_rty_load)     r_rty_tx <= w_rty_new;
      else if (w_rty_clr) r_rty_tx <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_sel_o   <= 4'h0;
      m_adr_o   <= 32'h0;
      m_dat_o   <= 32'h0;
      r_timer   <= '0;
      r_req_typ <= 4'h0;
      r_req_sid <= 6'h0;
      r_rsp_tx  <= '0;
      tmo_o     <= 1'b0;
    end else begin
      tmo_o <= w_tmo;
      if (w_rsp_clr) r_rsp_tx <= '0;
      if (w_pop) begin
        m_cyc_o   <= 1'b1;
        m_stb_o   <= 1'b1;
        m_we_o    <= (w_head.typ == PT_WRITE);
        m_sel_o   <= (w_head.typ == PT_WRITE) ? w_head.sel : 4'hF;
        m_adr_o   <= w_head.adr;
        m_dat_o   <= w_head.dat;
        r_timer   <= '0;
        r_req_typ <= w_head.typ;
        r_req_sid <= w_head.sid;
      end else if (w_finish) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
        m_we_o  <= 1'b0;
        m_sel_o <= 4'h0;
        if (r_req_typ != PT_WRITE) r_rsp_tx <= w_rsp_new;
      end else if (r_state == c_BUS) begin
        r_timer <= r_timer + c_TW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf68000_ring_server.sv
// ============================================================================
// tb_rf68000_ring_server : directed + randomized bench with a ring/response reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rf68000_ring_server;
  import rf68000_ring_pkg::*;

  localparam logic [5:0] SRV = 6'd62;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  packet_t     packet_i, packet_o, rpacket_i, rpacket_o;
  logic        m_cyc_o, m_stb_o, m_ack_i, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic        busy_o, drop_o, tmo_o;

  int n_tests = 0;
  int n_fail  = 0;

  rf68000_ring_server dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .packet_i(packet_i), .packet_o(packet_o),
    .rpacket_i(rpacket_i), .rpacket_o(rpacket_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .busy_o(busy_o), .drop_o(drop_o), .tmo_o(tmo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: what a ring root does to a passing packet
  function automatic packet_t m_fwd(input packet_t p);
    packet_t q = p;
    if ((p.sid | p.did) != 6'd0 && p.age >= 6'd63 && p.did != SRV) return '0;
    q.age = (p.age == 6'd63) ? 6'd63 : p.age + 6'd1;
    return q;
  endfunction

  function automatic packet_t m_rsp(input packet_t req, input logic [31:0] d);
    packet_t q = '0;
    q.sid = SRV;
    q.did = req.sid;
    q.ack = 1'b1;
    q.typ = (req.typ == PT_AREAD) ? PT_AACK : PT_ACK;
    q.adr = req.adr;
    q.dat = d;
    return q;
  endfunction

  function automatic packet_t m_rty(input packet_t req);
    packet_t q = '0;
    q.sid = SRV;
    q.did = req.sid;
    q.typ = PT_RETRY;
    q.adr = req.adr;
    return q;
  endfunction

  function automatic packet_t mk_req(input logic [3:0] typ);
    packet_t q = '0;
    q.did = SRV;
    q.sid = 6'($urandom_range(1, 61));
    q.age = 6'($urandom_range(0, 5));
    q.typ = typ;
    q.sel = 4'($urandom_range(1, 15));
    q.adr = $urandom;
    q.dat = $urandom;
    return q;
  endfunction

  function automatic packet_t mk_foreign();
    packet_t q = '0;
    q.did = 6'($urandom_range(1, 61));
    q.sid = 6'($urandom_range(1, 61));
    q.age = 6'($urandom_range(0, 20));
    q.typ = PT_ACK;
    q.adr = $urandom;
    q.dat = $urandom;
    return q;
  endfunction

  task automatic send(input packet_t p);
    packet_i = p;
    tick;
    packet_i = '0;
  endtask

  task automatic wait_cyc(input string tag);
    int n = 0;
    while (!m_cyc_o && n < 40) begin
      tick;
      n++;
    end
    check({tag, "_cyc"}, m_cyc_o, 1);
  endtask

  task automatic wait_rsp(input string tag, input packet_t exp);
    int n = 0;
    while ((rpacket_o.sid | rpacket_o.did) == 6'd0 && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_rsp"}, rpacket_o, exp);
  endtask

  task automatic serve(input string tag, input packet_t req, input int gap, input logic [31:0] d);
    logic seen;
    wait_cyc(tag);
    check({tag, "_we"}, m_we_o, req.typ == PT_WRITE);
    check({tag, "_sel"}, m_sel_o, (req.typ == PT_WRITE) ? req.sel : 4'hF);
    check({tag, "_adr"}, m_adr_o, req.adr);
    if (req.typ == PT_WRITE) check({tag, "_dat"}, m_dat_o, req.dat);
    repeat (gap) tick;
    m_ack_i = 1'b1;
    m_dat_i = d;
    tick;
    m_ack_i = 1'b0;
    m_dat_i = $urandom;
    check({tag, "_cyc_end"}, m_cyc_o, 0);
    if (req.typ == PT_WRITE) begin
      seen = 1'b0;
      repeat (4) begin
        tick;
        if ((rpacket_o.sid | rpacket_o.did) != 6'd0) seen = 1'b1;
      end
      check({tag, "_no_rsp"}, seen, 0);
    end else begin
      wait_rsp(tag, m_rsp(req, d));
    end
  endtask

  initial begin
    packet_t     r, a, b, occ, f, p;
    packet_t     q[6];
    logic [3:0]  types[3];
    logic [31:0] d;
    int          n;

    types[0] = PT_READ; types[1] = PT_AREAD; types[2] = PT_WRITE;
    packet_i = '0; rpacket_i = '0; m_ack_i = 1'b0; m_dat_i = 32'h0;

    tick; tick;
    check("rst_cyc", m_cyc_o, 0);
    check("rst_stb", m_stb_o, 0);
    check("rst_sel", m_sel_o, 0);
    check("rst_adr", m_adr_o, 0);
    check("rst_pkt", packet_o, 0);
    check("rst_rpkt", rpacket_o, 0);
    check("rst_flags", {busy_o, drop_o, tmo_o}, 0);
    rst_i = 1'b0;
    tick;
    check("idle_age", rpacket_o, m_fwd('0));

    // Basic read: latency and response contents
    r = mk_req(PT_READ);
    r.sid = 6'd3;
    r.adr = 32'h4000_0010;
    send(r);
    check("rd_consume", packet_o, 0);
    check("rd_busy", busy_o, 1);
    tick;
    check("rd_latency", {m_cyc_o, m_stb_o}, 2'b11);
    serve("rd", r, 2, 32'hCAFE_F00D);

    a = mk_req(PT_AREAD);
    a.sid = 6'd5;
    send(a);
    serve("ard", a, 1, $urandom);

    b = mk_req(PT_WRITE);
    b.sel = 4'h3;
    b.dat = 32'h1234_5678;
    send(b);
    serve("wr", b, 0, $urandom);
    check("wr_idle", busy_o, 0);

    for (int i = 0; i < 6; i++) begin
      r = mk_req(types[$urandom_range(0, 2)]);
      send(r);
      check("rnd_consume", packet_o, 0);
      serve("rnd", r, $urandom_range(0, 3), $urandom);
    end

    // Overflow: engine occupied, 4 fill FIFO, 5th retried, 6th recirculates
    occ = mk_req(PT_READ);
    send(occ);
    wait_cyc("occ");
    f = mk_foreign();
    rpacket_i = f;
    for (int k = 0; k < 6; k++) begin
      q[k] = mk_req(PT_READ);
      packet_i = q[k];
      tick;
      if (k < 5) check("ovf_consume", packet_o, 0);
      else       check("ovf_forward", packet_o, m_fwd(q[5]));
      check("ovf_ring", rpacket_o, m_fwd(f));
    end
    packet_i = '0;
    rpacket_i = '0;
    tick;
    check("ovf_retry", rpacket_o, m_rty(q[4]));
    serve("ovf_occ", occ, 0, $urandom);
    for (int k = 0; k < 4; k++) serve("ovf_q", q[k], $urandom_range(0, 2), $urandom);

    // Busy response ring: response held, no new bus cycle until a slot frees
    a = mk_req(PT_READ);
    b = mk_req(PT_AREAD);
    packet_i = a;
    tick;
    packet_i = b;
    tick;
    packet_i = '0;
    wait_cyc("blk");
    check("blk_adr", m_adr_o, a.adr);
    f = mk_foreign();
    rpacket_i = f;
    d = $urandom;
    m_ack_i = 1'b1;
    m_dat_i = d;
    tick;
    m_ack_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("blk_ring", rpacket_o, m_fwd(f));
      check("blk_nocyc", m_cyc_o, 0);
    end
    rpacket_i = '0;
    tick;
    check("blk_insert", rpacket_o, m_rsp(a, d));
    serve("blk_b", b, 1, $urandom);

    // Bus timeout
    r = mk_req(PT_READ);
    send(r);
    wait_cyc("tmo");
    n = 0;
    while (m_cyc_o && n < 300) begin
      tick;
      n++;
    end
    check("tmo_len", n, 256);
    check("tmo_pulse", tmo_o, 1);
    tick;
    check("tmo_pulse_end", tmo_o, 0);
    wait_rsp("tmo", m_rsp(r, 32'hFFFF_FFFF));

    // Ageing and removal rules
    p = mk_foreign();
    p.did = 6'd7; p.age = 6'd63; p.typ = PT_READ;
    send(p);
    check("age_drop_pkt", packet_o, 0);
    check("age_drop_flag", drop_o, 1);
    p.age = 6'd62;
    send(p);
    check("age_fwd_pkt", packet_o, m_fwd(p));
    check("age_fwd_flag", drop_o, 0);
    p = mk_req(PT_READ);
    p.did = 6'd63;
    send(p);
    check("bcast_fwd", packet_o, m_fwd(p));
    check("bcast_busy", busy_o, 0);
    p = mk_req(PT_ACK);
    send(p);
    check("bad_typ_pkt", packet_o, 0);
    check("bad_typ_drop", drop_o, 1);
    p = mk_foreign();
    p.age = 6'd63;
    rpacket_i = p;
    tick;
    rpacket_i = '0;
    check("rage_drop", {rpacket_o, drop_o}, {91'd0, 1'b1});

    // Asynchronous reset during a bus cycle
    r = mk_req(PT_WRITE);
    send(r);
    wait_cyc("arst");
    packet_i = mk_foreign();
    rpacket_i = mk_foreign();
    tick;
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_cyc", {m_cyc_o, m_stb_o}, 0);
    check("arst_busy", busy_o, 0);
    check("arst_rings", {packet_o, rpacket_o}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
